div_req_arbiter: RTL and testbench
==================================

// Module: div_req_arbiter
// PURPOSE
//  Shares one serial_divider datapath between NREQ requesters (firmware WB port, LA port, test engines).
//  Round-robin grant; per-requester valid/ready request and response channels.
//  Sequences the divider: operand load, start pulse, done wait, result return.
//  Handles divide-by-zero locally and bounds each divide with a timeout.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  XLEN     32  dividend/divisor/quotient/remainder width
//  TIMEOUT  64  max cycles in WAIT before abort; must exceed divider latency (XLEN+2)
// PORTS
//  clk_i            in   1          clock
//  reset_i          in   1          reset, asynchronous, active-high
//  req_valid_i      in   NREQ       request valid, one bit per requester
//  req_dividend_i   in   NREQ*XLEN  packed dividends; requester r at [r*XLEN +: XLEN]
//  req_divisor_i    in   NREQ*XLEN  packed divisors, same packing
//  req_ready_o      out  NREQ       request accepted (one-hot, IDLE only)
//  rsp_valid_o      out  NREQ       response valid, one-hot to granted requester
//  rsp_ready_i      in   NREQ       response consumed
//  rsp_quotient_o   out  XLEN       quotient, shared bus, qualified by rsp_valid_o
//  rsp_remainder_o  out  XLEN       remainder, shared bus
//  rsp_dbz_o        out  1          divisor was zero
//  rsp_timeout_o    out  1          divider did not finish within TIMEOUT
//  div_start_o      out  1          one-cycle start pulse to divider
//  div_dividend_o   out  XLEN       latched dividend, stable ISSUE..WAIT
//  div_divisor_o    out  XLEN       latched divisor
//  div_done_i       in   1          divider result valid pulse
//  div_quotient_i   in   XLEN       divider quotient
//  div_remainder_i  in   XLEN       divider remainder
//  busy_o           out  1          state != IDLE
//  grant_id_o       out  $clog2(NREQ)  index of current/last granted requester
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, every output 0, operand/result registers 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on divisor==0.
//  IDLE: winner = first r with req_valid_i[r], searching from pointer upward with wrap.
//   req_ready_o[winner]=1 combinationally; handshake = valid&ready in same cycle.
//   On handshake: latch operands and grant_id_o; divisor!=0 -> ISSUE, else -> RESP with
//   quotient={XLEN{1'b1}}, remainder=dividend, rsp_dbz_o=1.
//  ISSUE: div_start_o=1 for exactly one cycle; clear timeout counter; -> WAIT.
//  WAIT: div_done_i -> capture quotient/remainder, -> RESP.
//   Counter reaches TIMEOUT-1 without done -> RESP, results 0, rsp_timeout_o=1.
//   done and timeout in the same cycle: done wins, rsp_timeout_o=0.
//  RESP: rsp_valid_o[grant]=1, bus held stable until rsp_ready_i[grant];
//   then -> IDLE, pointer = grant+1 (wraps NREQ-1 -> 0), flags cleared.
//  Latency: handshake cycle 0, start cycle 1, done cycle k -> rsp_valid_o cycle k+1.
//   DBZ -> rsp_valid_o cycle 1.
//  div_done_i outside WAIT is ignored.
//  req_valid_i dropped before handshake: no grant, no side effects.
//  rsp_ready_i bits of non-granted requesters are ignored.
//  Back-to-back: new grant possible in the cycle after RESP completes (IDLE).
//  reset_i mid-operation: immediate return to reset state; in-flight request dropped;
//   divider is reset by the same reset_i.
// STRUCTURE
//  Shared package div_pkg: state enum {IDLE,ISSUE,WAIT,RESP}, DBZ quotient constant,
//   XLEN default.
//  One sub-module: rr_arbiter (NREQ req + pointer -> one-hot grant + index), combinational.
//  FSM, operand/result registers and timeout counter live in div_req_arbiter.
// TESTING
//  1. Single request r1: 100/7, divider model latency 34 -> rsp_valid_o=0010 at cycle 35,
//     quotient 14, remainder 2.
//  2. All 4 valid continuously -> grant order 0,1,2,3,0; no requester served twice in a row.
//  3. r2: 55/0 -> rsp_valid_o in cycle 1, quotient FFFF_FFFF, remainder 55, rsp_dbz_o=1,
//     div_start_o never pulses.
//  4. Divider model never asserts done -> RESP after 64 WAIT cycles, rsp_timeout_o=1, results 0;
//     next request serviced normally.
//  5. rsp_ready_i held low 10 cycles -> bus stable, no new grant;
//     stray div_done_i in IDLE ignored.
//  6. reset_i asserted during WAIT -> all outputs 0 same cycle; after release,
//     pointer 0 and r0 granted first.

Source files
------------

// File: rtl/div_req_arbiter_pkg.sv
// div_pkg: shared definitions for the divider request arbiter.
//  - div_state_e : sequencer states (IDLE, ISSUE, WAIT, RESP)
//  - XLEN_DEF    : default operand width
//  - DBZ_QUOT_FILL : all-ones pattern returned as quotient on divide-by-zero
//  - rr_next     : round-robin pointer advance with wrap
package div_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // Wide all-ones source; the top slices it to XLEN.
  localparam logic [63:0] DBZ_QUOT_FILL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_state_e;

  // Pointer position after serving requester idx out of n (wraps n-1 -> 0).
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/div_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//  req_i  : NREQ request bits
//  ptr_i  : highest-priority index for this pick
//  gnt_o  : one-hot grant (all zero when no request)
//  idx_o  : index of the granted requester (0 when none)
//  any_o  : at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int unsigned     pos;
  logic [IDW-1:0]  pos_idx;

  // Scan NREQ positions starting at the pointer; first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      pos_idx = IDW'(pos);
      if (!any_o && req_i[pos_idx]) begin
        any_o          = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/div_req_arbiter.sv
// div_req_arbiter: shares one serial divider among NREQ requesters.
//  Round-robin grant in IDLE, operand latch, one-cycle start pulse, bounded
//  wait for done, response held on a shared bus until the granted requester
//  consumes it. Divide-by-zero is answered locally without using the divider.
// Ports:
//  clk_i, reset_i                    clock, async active-high reset
//  req_valid_i/req_ready_o           per-requester request handshake
//  req_dividend_i/req_divisor_i      packed operands, requester r at [r*XLEN +: XLEN]
//  rsp_valid_o/rsp_ready_i           per-requester response handshake
//  rsp_quotient_o/rsp_remainder_o    shared result bus
//  rsp_dbz_o/rsp_timeout_o           result status flags
//  div_start_o/div_dividend_o/div_divisor_o   divider command side
//  div_done_i/div_quotient_i/div_remainder_i  divider result side
//  busy_o, grant_id_o                status
module div_req_arbiter
  import div_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*XLEN-1:0]    req_dividend_i,
  input  logic [NREQ*XLEN-1:0]    req_divisor_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [NREQ-1:0]         rsp_valid_o,
  input  logic [NREQ-1:0]         rsp_ready_i,
  output logic [XLEN-1:0]         rsp_quotient_o,
  output logic [XLEN-1:0]         rsp_remainder_o,
  output logic                    rsp_dbz_o,
  output logic                    rsp_timeout_o,
  output logic                    div_start_o,
  output logic [XLEN-1:0]         div_dividend_o,
  output logic [XLEN-1:0]         div_divisor_o,
  input  logic                    div_done_i,
  input  logic [XLEN-1:0]         div_quotient_i,
  input  logic [XLEN-1:0]         div_remainder_i,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);
  localparam logic [XLEN-1:0] DBZ_QUOT = DBZ_QUOT_FILL[XLEN-1:0];

  div_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] win_gnt;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic [XLEN-1:0] win_dvd;
  logic [XLEN-1:0] win_dvs;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Operand mux driven by the one-hot winner.
  always_comb begin
    win_dvd = '0;
    win_dvs = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (win_gnt[r]) begin
        win_dvd = req_dividend_i[r*XLEN +: XLEN];
        win_dvs = req_divisor_i[r*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    div_start_o = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is only offered to a valid winner, so any winner is a handshake.
        // Gated by reset so the combinational path also reads 0 while in reset.
        if (!reset_i) begin
          req_ready_o = win_gnt;
          if (win_any) begin
            grant_d = win_idx;
            dvd_d   = win_dvd;
            dvs_d   = win_dvs;
            if (win_dvs != '0) begin
              state_d = ISSUE;
            end else begin
              quot_d  = DBZ_QUOT;
              rem_d   = win_dvd;
              dbz_d   = 1'b1;
              tmo_d   = 1'b0;
              state_d = RESP;
            end
          end
        end
      end

      ISSUE: begin
        div_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        // Done is checked first so a completion on the final cycle still counts.
        if (div_done_i) begin
          quot_d  = div_quotient_i;
          rem_d   = div_remainder_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          quot_d  = '0;
          rem_d   = '0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (rsp_ready_i[grant_q]) begin
          ptr_d   = IDW'(rr_next(32'(grant_q), NREQ));
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_quotient_o  = quot_q;
  assign rsp_remainder_o = rem_q;
  assign rsp_dbz_o       = dbz_q;
  assign rsp_timeout_o   = tmo_q;
  assign div_dividend_o  = dvd_q;
  assign div_divisor_o   = dvs_q;
  assign busy_o          = (state_q != IDLE);
  assign grant_id_o      = grant_q;

endmodule

// File: tb/tb_div_req_arbiter.sv
module tb_div_req_arbiter;

  localparam int NREQ    = 4;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 33;  // start in cycle 1 -> done in cycle 34

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ*XLEN-1:0] req_dividend_i;
  logic [NREQ*XLEN-1:0] req_divisor_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  logic [XLEN-1:0]      rsp_quotient_o;
  logic [XLEN-1:0]      rsp_remainder_o;
  logic                 rsp_dbz_o;
  logic                 rsp_timeout_o;
  logic                 div_start_o;
  logic [XLEN-1:0]      div_dividend_o;
  logic [XLEN-1:0]      div_divisor_o;
  logic                 div_done_i;
  logic [XLEN-1:0]      div_quotient_i;
  logic [XLEN-1:0]      div_remainder_i;
  logic                 busy_o;
  logic [1:0]           grant_id_o;

  always #5 clk = ~clk;

  div_req_arbiter #(
    .NREQ    (NREQ),
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_dividend_i  (req_dividend_i),
    .req_divisor_i   (req_divisor_i),
    .req_ready_o     (req_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_quotient_o  (rsp_quotient_o),
    .rsp_remainder_o (rsp_remainder_o),
    .rsp_dbz_o       (rsp_dbz_o),
    .rsp_timeout_o   (rsp_timeout_o),
    .div_start_o     (div_start_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_done_i      (div_done_i),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i),
    .busy_o          (busy_o),
    .grant_id_o      (grant_id_o)
  );

  typedef struct packed {
    logic [3:0]  oh;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        tmo;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned pass_cnt  = 0;
  int unsigned tot_cnt   = 0;
  int unsigned start_cnt = 0;
  int          lat_cnt   = 0;
  logic        hang      = 1'b0;
  logic        stray     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Divider model: done LAT cycles after the start cycle, unless hang is set.
  initial begin
    div_done_i      = 1'b0;
    div_quotient_i  = '0;
    div_remainder_i = '0;
    forever begin
      @(posedge clk);
      #1;
      div_done_i = 1'b0;
      if (reset_i) begin
        lat_cnt = 0;
      end else begin
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            div_done_i      = 1'b1;
            div_quotient_i  = div_dividend_o / div_divisor_o;
            div_remainder_i = div_dividend_o % div_divisor_o;
          end
        end
        if (div_start_o) begin
          start_cnt++;
          if (!hang) lat_cnt = LAT;
        end
      end
      if (stray) begin
        div_done_i      = 1'b1;
        div_quotient_i  = 32'hDEAD_BEEF;
        div_remainder_i = 32'h0000_1234;
      end
    end
  end

  // Monitor: every response handshake pops and checks one scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i && ((rsp_valid_o & rsp_ready_i) != '0)) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_onehot", 64'(rsp_valid_o), 64'(mon_e.oh));
          chk("rsp_quot", 64'(rsp_quotient_o), 64'(mon_e.q));
          chk("rsp_rem", 64'(rsp_remainder_o), 64'(mon_e.r));
          chk("rsp_dbz", 64'(rsp_dbz_o), 64'(mon_e.dbz));
          chk("rsp_tmo", 64'(rsp_timeout_o), 64'(mon_e.tmo));
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    req_dividend_i[r*XLEN +: XLEN] = a;
    req_divisor_i[r*XLEN +: XLEN]  = b;
  endtask

  // Raise valid for r, wait for its handshake, drop valid in cycle 1.
  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << r;
    @(posedge clk);
    #1;
    set_ops(r, a, b);
    req_valid_i[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_o[r] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready", 64'(req_ready_o), 64'(oh));
    @(posedge clk);
    #1;
    req_valid_i[r] = 1'b0;
  endtask

  // Called right after issue(): returns the cycle index (handshake = 0) of rsp_valid_o.
  task automatic wait_rsp(output int n);
    n = 1;
    @(negedge clk);
    while (rsp_valid_o == '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  int   n;
  int   k;
  int   cyc;
  int   s0;
  int   order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] oh_exp;

  initial begin
    reset_i        = 1'b1;
    req_valid_i    = '0;
    req_dividend_i = '0;
    req_divisor_i  = '0;
    rsp_ready_i    = '1;

    // Reset state
    #2;
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_start", 64'(div_start_o), 64'd0);
    chk("rst_quot", 64'(rsp_quotient_o), 64'd0);
    chk("rst_grant", 64'(grant_id_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;

    // All four valid: grants 0,1,2,3,0
    for (int r = 0; r < 4; r++) set_ops(r, 32'(20 + r), 32'd3);
    sb.push_back('{4'b0001, 32'd6, 32'd2, 1'b0, 1'b0});
    sb.push_back('{4'b0010, 32'd7, 32'd0, 1'b0, 1'b0});
    sb.push_back('{4'b0100, 32'd7, 32'd1, 1'b0, 1'b0});
    sb.push_back('{4'b1000, 32'd7, 32'd2, 1'b0, 1'b0});
    sb.push_back('{4'b0001, 32'd6, 32'd2, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    req_valid_i = '1;
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (req_ready_o != '0) begin
        oh_exp = 4'b0001 << order[k];
        chk("rr_order", 64'(req_ready_o), 64'(oh_exp));
        k++;
      end
    end
    if (k < 5) chk("rr_timeout", 64'(k), 64'd5);
    @(posedge clk);
    #1;
    req_valid_i = '0;
    drain();

    // Single request r1: 100/7, response in cycle 35
    sb.push_back('{4'b0010, 32'd14, 32'd2, 1'b0, 1'b0});
    issue(1, 32'd100, 32'd7);
    wait_rsp(n);
    chk("lat_r1", 64'(n), 64'd35);
    chk("lat_r1_valid", 64'(rsp_valid_o), 64'b0010);
    drain();
    chk("grant_id_r1", 64'(grant_id_o), 64'd1);

    // Divide by zero on r2: response in cycle 1, divider untouched
    s0 = start_cnt;
    sb.push_back('{4'b0100, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0});
    issue(2, 32'd55, 32'd0);
    wait_rsp(n);
    chk("lat_dbz", 64'(n), 64'd1);
    drain();
    repeat (2) @(negedge clk);
    chk("dbz_no_start", 64'(start_cnt), 64'(s0));

    // Timeout on r3, then normal service on r0
    hang = 1'b1;
    sb.push_back('{4'b1000, 32'd0, 32'd0, 1'b0, 1'b1});
    issue(3, 32'd1000, 32'd10);
    wait_rsp(n);
    chk("lat_timeout", 64'(n), 64'd66);
    drain();
    hang = 1'b0;
    sb.push_back('{4'b0001, 32'd9, 32'd0, 1'b0, 1'b0});
    issue(0, 32'd81, 32'd9);
    wait_rsp(n);
    chk("lat_after_tmo", 64'(n), 64'd35);
    drain();

    // Response back-pressure: r1 held 10 cycles while r2 waits
    rsp_ready_i = 4'b1101;
    sb.push_back('{4'b0010, 32'd6, 32'd2, 1'b0, 1'b0});
    issue(1, 32'd50, 32'd8);
    wait_rsp(n);
    chk("lat_hold", 64'(n), 64'd35);
    set_ops(2, 32'd9, 32'd4);
    req_valid_i[2] = 1'b1;
    sb.push_back('{4'b0100, 32'd2, 32'd1, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid_o), 64'b0010);
      chk("hold_quot", 64'(rsp_quotient_o), 64'd6);
      chk("hold_rem", 64'(rsp_remainder_o), 64'd2);
      chk("hold_no_grant", 64'(req_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready_i = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o[2] && n < 100);
    chk("b2b_grant", 64'(req_ready_o), 64'b0100);
    chk("b2b_cycle", 64'(n), 64'd2);
    @(posedge clk);
    #1;
    req_valid_i[2] = 1'b0;
    drain();

    // Stray done in IDLE
    s0 = start_cnt;
    @(posedge clk);
    #2;
    stray = 1'b1;
    @(posedge clk);
    #2;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_done_seen", 64'(div_done_i), 64'd1);
    chk("stray_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    chk("stray_busy2", 64'(busy_o), 64'd0);
    chk("stray_rsp", 64'(rsp_valid_o), 64'd0);
    chk("stray_start", 64'(start_cnt), 64'(s0));

    // Reset during WAIT; then r0 wins over r3 from pointer 0
    issue(3, 32'd200, 32'd7);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    set_ops(0, 32'd5, 32'd5);
    set_ops(3, 32'd7, 32'd2);
    req_valid_i = 4'b1001;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_ready", 64'(req_ready_o), 64'd0);
    chk("mid_rst_dvd", 64'(div_dividend_o), 64'd0);
    chk("mid_rst_dvs", 64'(div_divisor_o), 64'd0);
    chk("mid_rst_grant", 64'(grant_id_o), 64'd0);
    chk("mid_rst_start", 64'(div_start_o), 64'd0);
    chk("mid_rst_rsp", 64'(rsp_valid_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    sb.push_back('{4'b0001, 32'd1, 32'd0, 1'b0, 1'b0});
    sb.push_back('{4'b1000, 32'd3, 32'd1, 1'b0, 1'b0});
    @(negedge clk);
    chk("post_rst_grant", 64'(req_ready_o), 64'b0001);
    @(posedge clk);
    #1;
    req_valid_i[0] = 1'b0;
    n = 0;
    while (!req_ready_o[3] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_r3", 64'(req_ready_o), 64'b1000);
    @(posedge clk);
    #1;
    req_valid_i[3] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
